// File: rtl/pe_feeder_if.sv
// Bundles the job-control, weight/input streams, PE control pins and
// result stream of the PE feeder. The shared PE data bus stays a plain
// inout on the feeder so that the tristate resolves at the top level.
interface pe_feeder_if #(
  parameter int DATA_W = 32,
  parameter int VEC_W  = 16
);
  logic              start;
  logic [VEC_W-1:0]  num_vec;
  logic              act_en;
  logic [DATA_W-1:0] wgt_data;
  logic              wgt_valid;
  logic              wgt_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        ctrl;
  logic              output_ctrl;
  logic              enable_act;
  logic [DATA_W-1:0] result_data;
  logic              result_valid;
  logic              result_ready;
  logic              busy;
  logic              done;

  // Feeder side
  modport master (
    input  start, num_vec, act_en, wgt_data, wgt_valid, in_data, in_valid,
           result_ready,
    output wgt_ready, in_ready, ctrl, output_ctrl, enable_act,
           result_data, result_valid, busy, done
  );

  // Environment side (sources, PE pins, downstream buffer)
  modport slave (
    output start, num_vec, act_en, wgt_data, wgt_valid, in_data, in_valid,
           result_ready,
    input  wgt_ready, in_ready, ctrl, output_ctrl, enable_act,
           result_data, result_valid, busy, done
  );
endinterface

// File: rtl/pe_feeder.sv
// Upstream sequencer for one PE: loads the weights once per job, then
// for each vector clears the accumulator, streams the input words, drains
// the fp MAC pipeline, turns the shared bus around and reads the result.
module pe_feeder #(
  parameter int DATA_W      = 32,
  parameter int NUM_WEIGHTS = 16,
  parameter int CNT_W       = 4,
  parameter int MAC_LAT     = 4,
  parameter int VEC_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  pe_feeder_if.master       bus,
  inout  wire  [DATA_W-1:0] data
);

  localparam int DRAIN_W = (MAC_LAT > 2) ? $clog2(MAC_LAT) : 1;

  localparam logic [2:0] CMD_NOP     = 3'd0;
  localparam logic [2:0] CMD_LOAD_W  = 3'd1;
  localparam logic [2:0] CMD_MAC     = 3'd2;
  localparam logic [2:0] CMD_CLR_ACC = 3'd3;
  localparam logic [2:0] CMD_READ    = 3'd4;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_LOAD_W = 4'd1,
    ST_CLR    = 4'd2,
    ST_RUN    = 4'd3,
    ST_DRAIN  = 4'd4,
    ST_TURN   = 4'd5,
    ST_CAPT   = 4'd6,
    ST_RES    = 4'd7,
    ST_FIN    = 4'd8
  } state_t;

  state_t              state_r;
  state_t              next_state_s;
  logic [CNT_W-1:0]    word_cnt_r;
  logic [DRAIN_W-1:0]  drain_cnt_r;
  logic [VEC_W-1:0]    vec_cnt_r;
  logic [VEC_W-1:0]    num_vec_r;
  logic                act_en_r;
  logic [DATA_W-1:0]   result_data_r;
  logic                result_valid_r;

  logic [2:0]          ctrl_s;
  logic                output_ctrl_s;
  logic                enable_act_s;
  logic                wgt_ready_s;
  logic                in_ready_s;
  logic                drive_en_s;
  logic [DATA_W-1:0]   drive_val_s;
  logic                busy_s;
  logic                done_s;

  logic                wgt_hs_s;
  logic                in_hs_s;
  logic                res_hs_s;
  logic                word_last_s;
  logic                drain_last_s;
  logic                vec_last_s;

  assign wgt_hs_s     = (state_r == ST_LOAD_W) && bus.wgt_valid;
  assign in_hs_s      = (state_r == ST_RUN) && bus.in_valid;
  assign res_hs_s     = (state_r == ST_RES) && result_valid_r && bus.result_ready;
  assign word_last_s  = (word_cnt_r == CNT_W'(NUM_WEIGHTS - 1));
  assign drain_last_s = (drain_cnt_r == DRAIN_W'(MAC_LAT - 1));
  // Compare against the latched count so the full VEC_W range is usable.
  assign vec_last_s   = ((vec_cnt_r + VEC_W'(1)) == num_vec_r);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and PE pin / stream handshake decode
  always_comb begin
    next_state_s  = state_r;
    ctrl_s        = CMD_NOP;
    output_ctrl_s = 1'b0;
    enable_act_s  = 1'b0;
    wgt_ready_s   = 1'b0;
    in_ready_s    = 1'b0;
    drive_en_s    = 1'b0;
    drive_val_s   = {DATA_W{1'b0}};
    busy_s        = 1'b1;
    done_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        busy_s = 1'b0;
        if (bus.start) begin
          next_state_s = ST_LOAD_W;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_LOAD_W: begin
        wgt_ready_s = 1'b1;
        if (bus.wgt_valid) begin
          ctrl_s      = CMD_LOAD_W;
          drive_en_s  = 1'b1;
          drive_val_s = bus.wgt_data;
          if (word_last_s) begin
            next_state_s = (num_vec_r == {VEC_W{1'b0}}) ? ST_FIN : ST_CLR;
          end else begin
            next_state_s = ST_LOAD_W;
          end
        end else begin
          next_state_s = ST_LOAD_W;
        end
      end
      ST_CLR: begin
        ctrl_s       = CMD_CLR_ACC;
        next_state_s = ST_RUN;
      end
      ST_RUN: begin
        in_ready_s = 1'b1;
        if (bus.in_valid) begin
          ctrl_s      = CMD_MAC;
          drive_en_s  = 1'b1;
          drive_val_s = bus.in_data;
          if (word_last_s) begin
            next_state_s = ST_DRAIN;
          end else begin
            next_state_s = ST_RUN;
          end
        end else begin
          next_state_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (drain_last_s) begin
          next_state_s = ST_TURN;
        end else begin
          next_state_s = ST_DRAIN;
        end
      end
      ST_TURN: begin
        // Bus turnaround: feeder already released Data, PE starts driving.
        ctrl_s        = CMD_READ;
        output_ctrl_s = 1'b1;
        enable_act_s  = act_en_r;
        next_state_s  = ST_CAPT;
      end
      ST_CAPT: begin
        ctrl_s        = CMD_READ;
        output_ctrl_s = 1'b1;
        enable_act_s  = act_en_r;
        next_state_s  = ST_RES;
      end
      ST_RES: begin
        if (res_hs_s) begin
          next_state_s = vec_last_s ? ST_FIN : ST_CLR;
        end else begin
          next_state_s = ST_RES;
        end
      end
      ST_FIN: begin
        done_s       = 1'b1;
        next_state_s = ST_IDLE;
      end
      default: begin
        busy_s       = 1'b0;
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Job parameters, word / drain / vector counters
  always_ff @(posedge clk) begin
    if (rst) begin
      num_vec_r   <= {VEC_W{1'b0}};
      act_en_r    <= 1'b0;
      word_cnt_r  <= {CNT_W{1'b0}};
      drain_cnt_r <= {DRAIN_W{1'b0}};
      vec_cnt_r   <= {VEC_W{1'b0}};
    end else begin
      if ((state_r == ST_IDLE) && bus.start) begin
        num_vec_r   <= bus.num_vec;
        act_en_r    <= bus.act_en;
        word_cnt_r  <= {CNT_W{1'b0}};
        drain_cnt_r <= {DRAIN_W{1'b0}};
        vec_cnt_r   <= {VEC_W{1'b0}};
      end
      if (wgt_hs_s || in_hs_s) begin
        word_cnt_r <= word_last_s ? {CNT_W{1'b0}} : (word_cnt_r + CNT_W'(1));
      end
      if (state_r == ST_DRAIN) begin
        drain_cnt_r <= drain_last_s ? {DRAIN_W{1'b0}} : (drain_cnt_r + DRAIN_W'(1));
      end
      if (res_hs_s) begin
        vec_cnt_r <= vec_cnt_r + VEC_W'(1);
      end
    end
  end

  // Result capture and valid/ready hold
  always_ff @(posedge clk) begin
    if (rst) begin
      result_data_r  <= {DATA_W{1'b0}};
      result_valid_r <= 1'b0;
    end else if (state_r == ST_CAPT) begin
      result_data_r  <= data;
      result_valid_r <= 1'b1;
    end else if (res_hs_s) begin
      result_valid_r <= 1'b0;
    end
  end

  assign data             = drive_en_s ? drive_val_s : {DATA_W{1'bz}};
  assign bus.ctrl         = ctrl_s;
  assign bus.output_ctrl  = output_ctrl_s;
  assign bus.enable_act   = enable_act_s;
  assign bus.wgt_ready    = wgt_ready_s;
  assign bus.in_ready     = in_ready_s;
  assign bus.busy         = busy_s;
  assign bus.done         = done_s;
  assign bus.result_data  = result_data_r;
  assign bus.result_valid = result_valid_r;

endmodule
